// File: rtl/writeback_unit.sv
// Pipelined writeback stage: in-order instruction queue, one-entry load
// response buffer, data select/extension and a registered register-file write port.
module writeback_unit #(
    parameter int WORD  = 64,
    parameter int DEPTH = 2,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_alu_result,
    input  logic [WORD-1:0]  in_pc,
    input  logic [1:0]       in_mem_to_reg,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_reg_write,
    input  logic             mem_rsp_valid,
    output logic             mem_rsp_ready,
    input  logic [WORD-1:0]  mem_rsp_data,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [WORD-1:0]  rf_wdata,
    output logic             busy,
    output logic             err_illegal,
    output logic             err_rsp
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_LINK = 2'b10,
        SRC_ILL  = 2'b11
    } src_e;

    typedef struct packed {
        logic [WORD-1:0]  alu_result;
        logic [WORD-1:0]  pc;
        src_e             src;
        logic [1:0]       size;
        logic             sgn;
        logic [RADDR-1:0] rd;
        logic             reg_write;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             rsp_full_q, rsp_full_d;
    logic [WORD-1:0]  rsp_data_q, rsp_data_d;
    logic             rf_we_q, rf_we_d;
    logic [RADDR-1:0] rf_waddr_q, rf_waddr_d;
    logic [WORD-1:0]  rf_wdata_q, rf_wdata_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_rsp_q, err_rsp_d;

    entry_t          head, in_entry;
    logic            head_valid, head_is_load, push, rsp_fire, retire;
    logic [WORD-1:0] load_raw, sel_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Keep the low 8/16/32/WORD bits and fill the rest with the sign bit or zero.
    function automatic logic [WORD-1:0] extend(input logic [WORD-1:0] raw,
                                               input logic [1:0] size,
                                               input logic sgn);
        logic [WORD-1:0] keep;
        logic            fill;
        case (size)
            2'b00:   begin keep = WORD'(8'hFF);         fill = raw[7];  end
            2'b01:   begin keep = WORD'(16'hFFFF);      fill = raw[15]; end
            2'b10:   begin keep = WORD'(32'hFFFF_FFFF); fill = raw[31]; end
            default: begin keep = '1;                   fill = 1'b0;    end
        endcase
        return (raw & keep) | ({WORD{sgn & fill}} & ~keep);
    endfunction

    assign in_entry = '{alu_result: in_alu_result, pc: in_pc, src: src_e'(in_mem_to_reg),
                        size: in_size, sgn: in_signed, rd: in_rd, reg_write: in_reg_write};

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        head_valid   = (count_q != '0);
        head_is_load = (head.src == SRC_LOAD);
        push         = in_valid & in_ready_q;
        rsp_fire     = mem_rsp_valid & ~rsp_full_q;
        retire       = head_valid & (~head_is_load | rsp_full_q | rsp_fire);
        load_raw     = rsp_full_q ? rsp_data_q : mem_rsp_data;

        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = retire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !retire) count_d = count_q + 1'b1;
        if (!push && retire) count_d = count_q - 1'b1;
        in_ready_d = (count_d != CW'(DEPTH));

        // A response meeting a load head bypasses the buffer; with no queued work it is dropped.
        rsp_full_d = rsp_full_q;
        rsp_data_d = rsp_data_q;
        err_rsp_d  = err_rsp_q;
        if (retire && head_is_load && rsp_full_q) rsp_full_d = 1'b0;
        if (rsp_fire) begin
            if (!head_valid) begin
                err_rsp_d = 1'b1;
            end else if (!head_is_load) begin
                rsp_full_d = 1'b1;
                rsp_data_d = mem_rsp_data;
            end
        end

        case (head.src)
            SRC_ALU:  sel_data = head.alu_result;
            SRC_LOAD: sel_data = extend(load_raw, head.size, head.sgn);
            SRC_LINK: sel_data = head.pc + WORD'(4);
            default:  sel_data = '0;
        endcase

        rf_we_d       = retire & head.reg_write & (head.rd != '1) & (head.src != SRC_ILL);
        rf_waddr_d    = rf_we_d ? head.rd : rf_waddr_q;
        rf_wdata_d    = rf_we_d ? sel_data : rf_wdata_q;
        err_illegal_d = err_illegal_q | (retire & (head.src == SRC_ILL));
    end

    // NOTE: queue storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            rsp_full_q    <= 1'b0;
            rsp_data_q    <= '0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            err_illegal_q <= 1'b0;
            err_rsp_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            rsp_full_q    <= rsp_full_d;
            rsp_data_q    <= rsp_data_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            err_illegal_q <= err_illegal_d;
            err_rsp_q     <= err_rsp_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_rsp_ready = ~rsp_full_q;
    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign busy          = (count_q != '0) | rsp_full_q;
    assign err_illegal   = err_illegal_q;
    assign err_rsp       = err_rsp_q;
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Pipelined successor to the single-cycle writeback path. Accepts retiring instructions from the MEM stage through a valid/ready handshake, holds them in an in-order queue of parametrised depth, and pairs each load with its memory response. Selects ALU, load or link (PC+4) data, applies size/sign extension to load data, and drives a registered register-file write port. Sits between the MEM/WB boundary and the register file of the pipelined core.

## Interface
- WORD, 64, datapath width in bits (power of two, >= 32)
- DEPTH, 2, instruction queue entries (>= 1)
- RADDR, 5, register address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  MEM stage offers an instruction
- in_ready  out  1  queue can accept (registered; = queue not full)
- in_alu_result  in  WORD  ALU result
- in_pc  in  WORD  instruction address
- in_mem_to_reg  in  2  source: 00 ALU, 01 load, 10 PC+4, 11 illegal
- in_size  in  2  load size: 00 byte, 01 half, 10 word, 11 dword
- in_signed  in  1  sign-extend load data
- in_rd  in  RADDR  destination register
- in_reg_write  in  1  instruction writes rd
- mem_rsp_valid  in  1  load data returning, in program order
- mem_rsp_ready  out  1  response buffer empty (registered)
- mem_rsp_data  in  WORD  raw load data, LSB-aligned
- rf_we  out  1  register write enable (registered)
- rf_waddr  out  RADDR  write address (registered)
- rf_wdata  out  WORD  write data (registered)
- busy  out  1  queue or response buffer non-empty
- err_illegal  out  1  sticky: source 11 retired
- err_rsp  out  1  sticky: response retired with no load pending

## Operation
- Queue: DEPTH-entry FIFO of {alu_result, pc, mem_to_reg, size, signed, rd, reg_write}. Push on in_valid & in_ready. Pointers wrap modulo DEPTH; count is 0..DEPTH.
- Response buffer: one entry. Fill on mem_rsp_valid & mem_rsp_ready; drained only when a load retires.
- Head retire conditions (at most one per cycle): non-load head retires unconditionally; load head retires only when response buffer is full, or mem_rsp_valid & mem_rsp_ready this cycle (same-cycle bypass of the buffer; buffer stays empty).
- Data select: 00 -> alu_result; 01 -> extended load data; 10 -> pc + 4 (mod 2^WORD); 11 -> no write, set err_illegal.
- Extension: take low 8/16/32/WORD bits per in_size; upper bits = sign bit if in_signed else 0. Size 11 ignores in_signed.
- Write suppression: rf_we = 0 when reg_write = 0, or rd = all ones (XZR), or source 11. Entry still retires.
- Response with no load anywhere in queue and queue empty: accepted, discarded, err_rsp set. Response arriving while head is non-load but a load is queued behind: buffered normally.
- Errors clear only on reset.

## Timing
- Reset: in_ready = 1, mem_rsp_ready = 1, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy = 0, err_* = 0; queue and buffer empty. Reset mid-operation discards all queued entries and buffered data with no write issued.
- Latency: instruction pushed in cycle t can retire in cycle t+1 at earliest; its rf_we pulse appears in cycle t+2 (one cycle after retire), lasting exactly one cycle.
- Throughput: one instruction per cycle for back-to-back non-loads with DEPTH >= 2, and for loads whose responses arrive one cycle after push.
- in_ready is registered from count: at full, a same-cycle retire does not allow a push; ready rises the following cycle.
- mem_rsp_ready low while buffer full; a second response waits for the pending load to retire.
- in_valid with in_ready low: no push, inputs ignored.

## Test plan
- ALU path: push {00, alu=0x1234, rd=3, rw=1} -> rf_we=1, waddr=3, wdata=0x1234 two cycles after push, single pulse.
- Load extension: load size 00 signed, rsp 0x...00F0 -> wdata 0xFFFF_FFFF_FFFF_FFF0; same unsigned -> 0xF0; size 01 signed rsp 0x8001 -> 0xFFFF_FFFF_FFFF_8001.
- Link and XZR: {10, pc=0x1000, rd=30} -> wdata 0x1004; {00, rd=31, rw=1} -> retires, rf_we stays 0.
- Ordering/stall: push load rd=1 then ALU rd=2, response 5 cycles later -> no writes until response; then rd=1 write followed next cycle by rd=2.
- Backpressure: DEPTH=2, loads pushed with no response -> in_ready low after 2 pushes, in_valid held; one response -> ready returns one cycle after retire; all data delivered in order.
- Errors/reset: response with empty queue -> err_rsp=1, no write; source 11 -> err_illegal=1, no write; assert rst_n mid-stall -> all outputs to reset values immediately, no stale write after release.
